// File: rtl/cordic_round_sat.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cordic_round_sat: 2-stage per-channel rounding (floor / half-up /          |
// | half-even) from WW to OW bits with clamp-or-wrap and overflow statistics.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cordic_round_sat #(
   parameter int NCH = 2,
   parameter int WW  = 15,
   parameter int OW  = 12,
   parameter int SAT = 1,
   parameter int CW  = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_ce,
   input  logic              i_valid,
   input  logic [1:0]        i_mode,
   input  logic [NCH*WW-1:0] i_data,
   input  logic              i_ovf_clr,
   output logic              o_valid,
   output logic [NCH*OW-1:0] o_data,
   output logic [NCH-1:0]    o_ovf,
   output logic              o_ovf_sticky,
   output logic [CW-1:0]     o_ovf_cnt
);

   localparam int          D            = WW - OW;
   localparam logic [1:0]  MODE_TRUNC   = 2'b00;
   localparam logic [1:0]  MODE_HALF_UP = 2'b01;
   localparam logic [OW-1:0] C_POS_MAX  = {1'b0, {(OW-1){1'b1}}};
   localparam logic [OW-1:0] C_NEG_MIN  = {1'b1, {(OW-1){1'b0}}};
   localparam logic [CW-1:0] C_CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   logic                  v1_q, v1_d;
   logic [NCH-1:0][WW:0]  s1_q, s1_d;
   logic                  v2_q, v2_d;
   logic [NCH*OW-1:0]     data_q, data_d;
   logic [NCH-1:0]        ovf_q, ovf_d;
   logic                  sticky_q, sticky_d;
   logic [CW-1:0]         cnt_q, cnt_d;

   logic [NCH-1:0][WW:0]  sum;
   logic [NCH*OW-1:0]     res;
   logic [NCH-1:0]        ovf_new;
   logic                  ovf_evt;

   genvar k;
   generate
      for (k = 0; k < NCH; k++) begin : g_ch
         logic [WW-1:0] x;
         logic [WW:0]   r;
         logic [OW:0]   q;
         logic          fits;
         logic          unused_lsbs;

         assign x = i_data[k*WW +: WW];

         always_comb begin
            r = '0;
            case (i_mode)
               MODE_TRUNC:   r = '0;
               MODE_HALF_UP: r[D-1] = 1'b1;
               // Bias one below half when the kept LSB is even so exact ties round to even.
               default:      r[D-1:0] = {x[D], {(D-1){~x[D]}}};
            endcase
         end

         assign sum[k] = {x[WW-1], x} + r;

         assign q           = s1_q[k][WW:D];
         assign fits        = (q[OW] == q[OW-1]);
         assign unused_lsbs = ^s1_q[k][D-1:0];
         assign ovf_new[k]  = ~fits;
         assign res[k*OW +: OW] = (fits || (SAT == 0)) ? q[OW-1:0]
                                : (q[OW] ? C_NEG_MIN : C_POS_MAX);
      end
   endgenerate

   always_comb begin
      v1_d     = v1_q;
      s1_d     = s1_q;
      v2_d     = v2_q;
      data_d   = data_q;
      ovf_d    = ovf_q;
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      ovf_evt  = 1'b0;

      if (i_ce) begin
         v1_d = i_valid;
         s1_d = sum;
         v2_d = v1_q;
         if (v1_q) begin
            data_d  = res;
            ovf_d   = ovf_new;
            ovf_evt = |ovf_new;
         end
      end

      // A clear coinciding with a new event leaves that event counted.
      if (i_ovf_clr) begin
         sticky_d = ovf_evt;
         cnt_d    = ovf_evt ? C_CNT_ONE : '0;
      end else if (ovf_evt) begin
         sticky_d = 1'b1;
         if (cnt_q != '1) cnt_d = cnt_q + C_CNT_ONE;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         v1_q     <= 1'b0;
         s1_q     <= '0;
         v2_q     <= 1'b0;
         data_q   <= '0;
         ovf_q    <= '0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         v1_q     <= v1_d;
         s1_q     <= s1_d;
         v2_q     <= v2_d;
         data_q   <= data_d;
         ovf_q    <= ovf_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
      end
   end

   assign o_valid      = v2_q;
   assign o_data       = data_q;
   assign o_ovf        = ovf_q;
   assign o_ovf_sticky = sticky_q;
   assign o_ovf_cnt    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_round_sat.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cordic_round_sat: directed vector bench for cordic_round_sat, with a   |
// | clamping instance and a wrapping 2-bit-counter instance.  Revision: 1.0    |
// +----------------------------------------------------------------------------+
module tb_cordic_round_sat;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ce = 1'b0;
   logic        valid = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic [29:0] data = '0;
   logic        clr = 1'b0;

   logic        a_valid, w_valid;
   logic [23:0] a_data, w_data;
   logic [1:0]  a_ovf, w_ovf;
   logic        a_sticky, w_sticky;
   logic [15:0] a_cnt;
   logic [1:0]  w_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   cordic_round_sat dut_a (
      .i_clk(clk), .i_reset(reset), .i_ce(ce), .i_valid(valid), .i_mode(mode),
      .i_data(data), .i_ovf_clr(clr), .o_valid(a_valid), .o_data(a_data),
      .o_ovf(a_ovf), .o_ovf_sticky(a_sticky), .o_ovf_cnt(a_cnt)
   );

   cordic_round_sat #(.SAT(0), .CW(2)) dut_w (
      .i_clk(clk), .i_reset(reset), .i_ce(ce), .i_valid(valid), .i_mode(mode),
      .i_data(data), .i_ovf_clr(clr), .o_valid(w_valid), .o_data(w_data),
      .o_ovf(w_ovf), .o_ovf_sticky(w_sticky), .o_ovf_cnt(w_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  mode;
      logic [14:0] ch0;
      logic [14:0] ch1;
      logic [11:0] e0;
      logic [11:0] e1;
      logic [1:0]  eovf;
      logic [11:0] w0;
      logic [11:0] w1;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{2'b10, 15'h0004, 15'h0000, 12'h000, 12'h000, 2'b00, 12'h000, 12'h000};
      vecs[1] = '{2'b01, 15'h0004, 15'h000C, 12'h001, 12'h002, 2'b00, 12'h001, 12'h002};
      vecs[2] = '{2'b00, 15'h0004, 15'h7FFC, 12'h000, 12'hFFF, 2'b00, 12'h000, 12'hFFF};
      vecs[3] = '{2'b10, 15'h000C, 15'h3FFF, 12'h002, 12'h7FF, 2'b10, 12'h002, 12'h800};
      vecs[4] = '{2'b00, 15'h3FFF, 15'h4000, 12'h7FF, 12'h800, 2'b00, 12'h7FF, 12'h800};
      vecs[5] = '{2'b01, 15'h3FFC, 15'h4003, 12'h7FF, 12'h800, 2'b01, 12'h800, 12'h800};
      vecs[6] = '{2'b11, 15'h0014, 15'h0008, 12'h002, 12'h001, 2'b00, 12'h002, 12'h001};
      vecs[7] = '{2'b10, 15'h7FF4, 15'h7FEC, 12'hFFE, 12'hFFE, 2'b00, 12'hFFE, 12'hFFE};

      #1 reset = 1'b1;
      #1;
      chk("rst_valid",  a_valid,  1'b0);
      chk("rst_data",   a_data,   24'h0);
      chk("rst_ovf",    a_ovf,    2'b00);
      chk("rst_sticky", a_sticky, 1'b0);
      chk("rst_cnt",    a_cnt,    16'h0);
      tick();
      tick();
      reset = 1'b0;

      // Single-sample vectors, each observed at its one- and two-cycle points.
      for (int i = 0; i < 8; i++) begin
         ce    = 1'b1;
         valid = 1'b1;
         mode  = vecs[i].mode;
         data  = {vecs[i].ch1, vecs[i].ch0};
         tick();
         valid = 1'b0;
         chk($sformatf("v%0d_lat1_valid", i), a_valid, 1'b0);
         tick();
         chk($sformatf("v%0d_valid", i), a_valid, 1'b1);
         chk($sformatf("v%0d_data", i),  a_data, {vecs[i].e1, vecs[i].e0});
         chk($sformatf("v%0d_ovf", i),   a_ovf, vecs[i].eovf);
         chk($sformatf("v%0d_wdata", i), w_data, {vecs[i].w1, vecs[i].w0});
         chk($sformatf("v%0d_wovf", i),  w_ovf, vecs[i].eovf);
      end
      tick();
      chk("hold_valid", a_valid, 1'b0);
      chk("hold_data",  a_data, {vecs[7].e1, vecs[7].e0});
      chk("tbl_sticky", a_sticky, 1'b1);
      chk("tbl_cnt",    a_cnt, 16'd2);
      chk("tbl_wcnt",   w_cnt, 2'd2);

      // Clear acts with the pipeline stalled.
      ce  = 1'b0;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_sticky", a_sticky, 1'b0);
      chk("clr_cnt",    a_cnt, 16'd0);
      chk("clr_wcnt",   w_cnt, 2'd0);

      // Clear coinciding with an overflowing output.
      ce    = 1'b1;
      valid = 1'b1;
      mode  = 2'b10;
      data  = {15'h3FFF, 15'h000C};
      tick();
      valid = 1'b0;
      clr   = 1'b1;
      tick();
      clr = 1'b0;
      chk("coinc_ovf",    a_ovf, 2'b10);
      chk("coinc_sticky", a_sticky, 1'b1);
      chk("coinc_cnt",    a_cnt, 16'd1);
      chk("coinc_wcnt",   w_cnt, 2'd1);

      // Five more overflows: 16-bit counter reaches 6, 2-bit counter stops at 3.
      valid = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      valid = 1'b0;
      tick();
      tick();
      chk("sat_cnt",  a_cnt, 16'd6);
      chk("sat_wcnt", w_cnt, 2'd3);
      chk("sat_wsticky", w_sticky, 1'b1);

      // Three sets with i_ce alternating 1,0,1,0,...
      mode = 2'b00;
      for (int c = 0; c < 10; c++) begin
         int e;
         ce = (c % 2 == 0);
         if (c % 2 == 0 && c / 2 < 3) begin
            valid = 1'b1;
            data  = {15'h0, 15'((c / 2 + 1) * 8)};
         end else begin
            valid = 1'b0;
         end
         tick();
         e = c - (c % 2);
         chk($sformatf("ce%0d_valid", c), a_valid, (e == 2 || e == 4 || e == 6));
         if (e >= 2)
            chk($sformatf("ce%0d_data", c), a_data[11:0], 12'((e / 2 > 3) ? 3 : e / 2));
      end

      // Asynchronous reset mid-stream.
      ce    = 1'b1;
      valid = 1'b1;
      mode  = 2'b10;
      data  = {15'h3FFF, 15'h000C};
      tick();
      tick();
      chk("pre_rst_valid", a_valid, 1'b1);
      #3 reset = 1'b1;
      valid = 1'b0;
      #1;
      chk("arst_valid",  a_valid,  1'b0);
      chk("arst_data",   a_data,   24'h0);
      chk("arst_ovf",    a_ovf,    2'b00);
      chk("arst_sticky", a_sticky, 1'b0);
      chk("arst_cnt",    a_cnt,    16'h0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("post_rst%0d_valid", i), a_valid, 1'b0);
         chk($sformatf("post_rst%0d_data", i),  a_data, 24'h0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
